// File: rtl/fir_mon_pkg.sv
// fir_mon_pkg: shared states, default widths and saturating-add helpers for the FIR error monitor
package fir_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  localparam int ACC_W_DEF = 64;
  localparam int SAT_W = 128;
  typedef logic signed [SAT_W:0] wide_t;
  // operands arrive extended to SAT_W; the extra bit keeps the exact sum
  function automatic wide_t wide_sum(input logic [SAT_W-1:0] a, b, input logic sgn);
    return $signed({sgn & a[SAT_W-1], a}) + $signed({sgn & b[SAT_W-1], b});
  endfunction
  function automatic wide_t lim_hi(input int w, input logic sgn);
    return (wide_t'(1) <<< (sgn ? w - 1 : w)) - wide_t'(1);
  endfunction
  function automatic wide_t lim_lo(input int w, input logic sgn);
    return sgn ? -(wide_t'(1) <<< (w - 1)) : '0;
  endfunction
  function automatic logic sat_ovf(input logic [SAT_W-1:0] a, b, input int w, input logic sgn);
    wide_t s;
    s = wide_sum(a, b, sgn);
    return s > lim_hi(w, sgn) || s < lim_lo(w, sgn);
  endfunction
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a, b, input int w, input logic sgn);
    wide_t s, hi, lo;
    s = wide_sum(a, b, sgn);
    hi = lim_hi(w, sgn);
    lo = lim_lo(w, sgn);
    return SAT_W'(s > hi ? hi : s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/fir_mon_err_stage.sv
// fir_mon_err_stage: first pipeline stage, registers err, |err| and |accu| for each accepted pair
module fir_mon_err_stage import fir_mon_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pair_valid,
  input  logic [DATA_W-1:0]        appr,
  input  logic [DATA_W-1:0]        accu,
  output logic                     valid,
  output logic signed [DATA_W:0]   err,
  output logic [DATA_W:0]          abs_err,
  output logic [DATA_W:0]          abs_accu
);
  logic signed [DATA_W:0] d, a;
  assign d = $signed({appr[DATA_W-1], appr}) - $signed({accu[DATA_W-1], accu});
  assign a = $signed({accu[DATA_W-1], accu});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      err <= '0;
      abs_err <= '0;
      abs_accu <= '0;
    end else begin
      valid <= pair_valid;
      if (pair_valid) begin
        err <= d;
        abs_err <= d[DATA_W] ? -d : d;
        abs_accu <= a[DATA_W] ? -a : a;
      end
    end
endmodule

// File: rtl/fir_error_monitor.sv
// fir_error_monitor: windowed error statistics between approximate and accurate FIR outputs
// Define FIR_ERR_MAX_EN to build the running max |err| tracker; otherwise max_abs_err is 0.
module fir_error_monitor import fir_mon_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] appr,
  input  logic [DATA_W-1:0] accu,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [ACC_W-1:0]  err_sum,
  output logic [ACC_W-1:0]  abs_res_sum,
  output logic [ACC_W-1:0]  sq_err_sum,
  output logic [DATA_W:0]   max_abs_err,
  output logic              sat
);
  state_t state, next;
  logic [CNT_W-1:0] n_lat;
  logic start_ok, accept, s1_valid, ovf;
  logic signed [DATA_W:0] s1_err;
  logic [DATA_W:0] s1_abs_err, s1_abs_accu;
  logic [2*DATA_W+1:0] sq;
  logic [ACC_W-1:0] es_nx, as_nx, ss_nx;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign in_ready = state == RUN && count < n_lat;
  assign accept = in_valid && in_ready;
  // squaring |err| gives the same value as err^2 without a signed multiplier
  assign sq = (2*DATA_W+2)'(s1_abs_err) * (2*DATA_W+2)'(s1_abs_err);
  fir_mon_err_stage #(.DATA_W(DATA_W)) u_err (
    .clk(clk),
    .rst_n(rst_n),
    .pair_valid(accept),
    .appr(appr),
    .accu(accu),
    .valid(s1_valid),
    .err(s1_err),
    .abs_err(s1_abs_err),
    .abs_accu(s1_abs_accu)
  );
  always_comb
    next = start_ok ? (num_samples == '0 ? DONE : RUN)
         : (state == RUN && accept && count + CNT_W'(1) == n_lat) ? DRAIN
         : state == DRAIN ? DONE : state;
  always_comb begin
    es_nx = ACC_W'(sat_add(SAT_W'($signed(err_sum)), SAT_W'(s1_err), ACC_W, 1'b1));
    as_nx = ACC_W'(sat_add(SAT_W'(abs_res_sum), SAT_W'(s1_abs_accu), ACC_W, 1'b0));
    ss_nx = ACC_W'(sat_add(SAT_W'(sq_err_sum), SAT_W'(sq), ACC_W, 1'b0));
    ovf = sat_ovf(SAT_W'($signed(err_sum)), SAT_W'(s1_err), ACC_W, 1'b1)
        | sat_ovf(SAT_W'(abs_res_sum), SAT_W'(s1_abs_accu), ACC_W, 1'b0)
        | sat_ovf(SAT_W'(sq_err_sum), SAT_W'(sq), ACC_W, 1'b0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      n_lat <= '0;
      count <= '0;
      err_sum <= '0;
      abs_res_sum <= '0;
      sq_err_sum <= '0;
      sat <= 1'b0;
    end else begin
      state <= next;
      busy <= next == RUN || next == DRAIN;
      done <= next == DONE;
      if (start_ok) begin
        n_lat <= num_samples;
        count <= '0;
        err_sum <= '0;
        abs_res_sum <= '0;
        sq_err_sum <= '0;
        sat <= 1'b0;
      end else begin
        if (accept) count <= count + CNT_W'(1);
        if (s1_valid) begin
          err_sum <= es_nx;
          abs_res_sum <= as_nx;
          sq_err_sum <= ss_nx;
          sat <= sat | ovf;
        end
      end
    end
`ifdef FIR_ERR_MAX_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) max_abs_err <= '0;
    else if (start_ok) max_abs_err <= '0;
    else if (s1_valid && s1_abs_err > max_abs_err) max_abs_err <= s1_abs_err;
`else
  assign max_abs_err = '0;
`endif
endmodule
